aes128_cbc_ctrl: RTL

- Initiator-side sequencer that drives the team's AES-128 core to process a stream of 128-bit blocks in CBC mode.
- Issues key loads, feeds blocks, and waits for results, using the core's reset_key/key_ready and load_data/cipher_ready handshakes.
- Applies CBC chaining with valid/ready streaming on the input and output sides.
- Sits between the system DMA/stream fabric and the AES-128 core; does not instantiate the core.

---
 rtl/aes128_cbc_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/aes128_cbc_ctrl.sv
// CBC-mode sequencer for the AES-128 core: loads the key, feeds chained blocks
// through the core's handshakes and streams results out with valid/ready.
module aes128_cbc_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [127:0]     key_i,
  input  logic [127:0]     iv_i,
  input  logic             mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [127:0]     in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [127:0]     out_data_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] blk_cnt_o,
  output logic             core_reset_key_o,
  output logic [127:0]     core_cipher_key_o,
  output logic             core_load_data_o,
  output logic [127:0]     core_text_o,
  output logic             core_enc_or_dec_o,
  input  logic             core_key_ready_i,
  input  logic             core_cipher_ready_i,
  input  logic [127:0]     core_text_i
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KEYLOAD, S_KEYWAIT, S_FETCH, S_LOAD, S_RUN, S_EMIT
  } state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [127:0]     key_q, key_d, chain_q, chain_d, saved_q, saved_d;
  logic [127:0]     text_q, text_d, out_q, out_d;
  logic             mode_q, mode_d, last_q, last_d;
  logic             err_q, err_d, done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_hit;

  // Fires on the TIMEOUT-th consecutive waiting cycle.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      key_q   <= '0;
      chain_q <= '0;
      saved_q <= '0;
      text_q  <= '0;
      out_q   <= '0;
      mode_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      key_q   <= key_d;
      chain_q <= chain_d;
      saved_q <= saved_d;
      text_q  <= text_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      err_q   <= err_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    key_d   = key_q;
    chain_d = chain_q;
    saved_d = saved_q;
    text_d  = text_q;
    out_d   = out_q;
    mode_d  = mode_q;
    last_d  = last_q;
    err_d   = err_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          key_d   = key_i;
          mode_d  = mode_i;
          chain_d = iv_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_KEYLOAD;
        end
      end
      S_KEYLOAD: begin
        tmo_d   = '0;
        state_d = S_KEYWAIT;
      end
      S_KEYWAIT: begin
        if (core_key_ready_i) begin
          state_d = S_FETCH;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_FETCH: begin
        if (in_valid_i) begin
          text_d  = mode_q ? (in_data_i ^ chain_q) : in_data_i;
          saved_d = in_data_i;
          last_d  = in_last_i;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tmo_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Decrypt chains on the saved ciphertext, encrypt on the fresh result.
        if (core_cipher_ready_i) begin
          out_d   = mode_q ? core_text_i : (core_text_i ^ chain_q);
          chain_d = mode_q ? core_text_i : saved_q;
          state_d = S_EMIT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o            = (state_q != S_IDLE);
    in_ready_o        = (state_q == S_FETCH);
    out_valid_o       = (state_q == S_EMIT);
    core_reset_key_o  = (state_q == S_KEYLOAD);
    core_load_data_o  = (state_q == S_LOAD);
    out_data_o        = out_q;
    out_last_o        = last_q;
    done_o            = done_q;
    err_o             = err_q;
    blk_cnt_o         = cnt_q;
    core_cipher_key_o = key_q;
    core_text_o       = text_q;
    core_enc_or_dec_o = mode_q;
  end

endmodule
